cut_bist_ctrl: RTL and testbench

- Sequential stimulus/response harness that drives an N_IN-input, N_OUT-output combinational circuit-under-test (CUT), such as a gate-level test circuit.
- It walks every input vector exhaustively, waits a settle time, captures the CUT outputs and compacts them into a MISR signature.
- At the end it compares the signature against a golden value. It is the initiator/checker end of the CUT's input/output interface, used for on-chip self-test of netlist test circuits.

---
 rtl/cut_bist_ctrl.sv | 135 +++++++++++++
 tb/tb_cut_bist_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cut_bist_ctrl.sv
// Exhaustive-vector BIST harness for a combinational circuit-under-test:
// drives every input vector, waits a settle time, compacts responses into a MISR.
module cut_bist_ctrl #(
  parameter int               N_IN   = 2,
  parameter int               N_OUT  = 1,
  parameter int               SIG_W  = 8,
  parameter logic [SIG_W-1:0] POLY   = 8'h1D,
  parameter logic [SIG_W-1:0] SEED   = '0,
  parameter int               SETTLE = 1,
  parameter logic [SIG_W-1:0] GOLDEN = 8'h0E
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [N_IN-1:0]  cut_in,
  input  logic [N_OUT-1:0] cut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature,
  output logic [N_IN-1:0]  vec_idx
);

  localparam int              CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);
  localparam logic [N_IN-1:0]  LAST_VEC = '1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [N_IN-1:0]   vec_idx_q, vec_idx_d;
  logic [SIG_W-1:0]  sig_q, sig_d, sig_next;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;

  // One MISR step: shift, fold the MSB back through POLY, inject the response.
  assign sig_next = {sig_q[SIG_W-2:0], 1'b0}
                  ^ (sig_q[SIG_W-1] ? POLY : '0)
                  ^ SIG_W'(cut_out);

  always_comb begin
    // NOTE: every signal gets a default here so no path can infer a latch.
    state_d   = state_q;
    vec_idx_d = vec_idx_q;
    sig_d     = sig_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    pass_d    = pass_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          vec_idx_d = '0;
          sig_d     = SEED;
          pass_d    = 1'b0;
          cnt_d     = CNT_LOAD;
          state_d   = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (abort) begin
          pass_d  = 1'b0;
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_CAPTURE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_CAPTURE: begin
        if (abort) begin
          pass_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          sig_d = sig_next;
          if (vec_idx_q == LAST_VEC) begin
            done_d  = 1'b1;
            pass_d  = (sig_next == GOLDEN);
            state_d = S_DONE;
          end else begin
            vec_idx_d = vec_idx_q + 1'b1;
            cnt_d     = CNT_LOAD;
            state_d   = S_SETTLE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_SETTLE) || (state_d == S_CAPTURE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values computed above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      vec_idx_q <= '0;
      sig_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_idx_q <= vec_idx_d;
      sig_q     <= sig_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  assign cut_in    = vec_idx_q;
  assign vec_idx   = vec_idx_q;
  assign signature = sig_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;

endmodule

// File: tb/tb_cut_bist_ctrl.sv
// Bench for cut_bist_ctrl: two instances (SETTLE=1 and SETTLE=3) driving a
// bench-modelled 2-input CUT; results are scoreboarded at each done pulse.
module tb_cut_bist_ctrl;

  localparam int NVEC = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // CUT behaviour: 0 = NAND2, 1 = AND2, 2 = output stuck-at-1
  int mode = 0;
  int sel  = 0;

  logic       start_a = 1'b0, abort_a = 1'b0;
  logic [1:0] cut_in_a, vec_idx_a;
  logic [0:0] cut_out_a;
  logic       busy_a, done_a, pass_a;
  logic [7:0] sig_a;

  logic       start_b = 1'b0, abort_b = 1'b0;
  logic [1:0] cut_in_b, vec_idx_b;
  logic [0:0] cut_out_b;
  logic       busy_b, done_b, pass_b;
  logic [7:0] sig_b;

  function automatic logic cut_fn(input int m, input logic [1:0] v);
    case (m)
      0:       return ~(v[0] & v[1]);
      1:       return v[0] & v[1];
      default: return 1'b1;
    endcase
  endfunction

  always_comb cut_out_a = cut_fn(mode, cut_in_a);
  always_comb cut_out_b = cut_fn(mode, cut_in_b);

  cut_bist_ctrl #(.SETTLE(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
    .cut_in(cut_in_a), .cut_out(cut_out_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .signature(sig_a), .vec_idx(vec_idx_a)
  );

  cut_bist_ctrl #(.SETTLE(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
    .cut_in(cut_in_b), .cut_out(cut_out_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .signature(sig_b), .vec_idx(vec_idx_b)
  );

  logic [1:0] m_cut_in, m_vec_idx;
  logic       m_busy, m_done, m_pass;
  logic [7:0] m_sig;
  always_comb begin
    m_cut_in  = sel ? cut_in_b  : cut_in_a;
    m_vec_idx = sel ? vec_idx_b : vec_idx_a;
    m_busy    = sel ? busy_b    : busy_a;
    m_done    = sel ? done_b    : done_a;
    m_pass    = sel ? pass_b    : pass_a;
    m_sig     = sel ? sig_b     : sig_a;
  end

  typedef struct {
    int         inst;
    int         settle;
    int         cut_mode;
    logic [7:0] exp_sig;
    logic       exp_pass;
  } vec_t;

  typedef struct {
    logic [7:0] sig;
    logic       pass;
    int         latency;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic set_start(input logic v);
    if (sel != 0) start_b = v; else start_a = v;
  endtask

  // Pulses start, follows the run cycle by cycle and scores the result
  // against the scoreboard head at the done pulse.
  task automatic run(input int settle, input int repulse_j);
    int   j;
    int   busy_cnt;
    bit   got_done;
    exp_t e;
    logic [7:0] fin_sig;
    j = 0; busy_cnt = 0; got_done = 0;
    @(negedge clk);
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
    while (j < 200) begin
      if (m_done) begin
        got_done = 1;
        break;
      end
      if (m_busy) busy_cnt++;
      check("cut_in_step", 32'(m_cut_in), 32'(j / (settle + 1)));
      check("run_busy", 32'(m_busy), 32'(1));
      check("run_pass_clear", 32'(m_pass), 32'(0));
      set_start(j == repulse_j);
      @(negedge clk);
      j++;
    end
    set_start(1'b0);
    if (!got_done) begin
      check("done_timeout", 32'(0), 32'(1));
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    check("signature", 32'(m_sig), 32'(e.sig));
    check("pass", 32'(m_pass), 32'(e.pass));
    check("done_latency", 32'(j), 32'(e.latency));
    check("busy_cycles", 32'(busy_cnt), 32'(e.latency));
    check("busy_in_done", 32'(m_busy), 32'(0));
    fin_sig = m_sig;
    @(negedge clk);
    check("done_one_cycle", 32'(m_done), 32'(0));
    check("sig_hold", 32'(m_sig), 32'(fin_sig));
    check("pass_hold", 32'(m_pass), 32'(e.pass));
    check("cut_in_hold", 32'(m_cut_in), 32'(NVEC - 1));
  endtask

  task automatic push_exp(input logic [7:0] s, input logic p, input int settle);
    exp_t e;
    e.sig = s; e.pass = p; e.latency = NVEC * (settle + 1);
    sb.push_back(e);
  endtask

  initial begin
    vec_t tbl[4];
    bit   saw_done;
    tbl[0] = '{inst: 0, settle: 1, cut_mode: 0, exp_sig: 8'h0E, exp_pass: 1'b1};
    tbl[1] = '{inst: 0, settle: 1, cut_mode: 1, exp_sig: 8'h01, exp_pass: 1'b0};
    tbl[2] = '{inst: 0, settle: 1, cut_mode: 2, exp_sig: 8'h0F, exp_pass: 1'b0};
    tbl[3] = '{inst: 1, settle: 3, cut_mode: 0, exp_sig: 8'h0E, exp_pass: 1'b1};

    // Reset state
    #12;
    check("rst_cut_in", 32'(cut_in_a), 32'(0));
    check("rst_busy", 32'(busy_a), 32'(0));
    check("rst_done", 32'(done_a), 32'(0));
    check("rst_pass", 32'(pass_a), 32'(0));
    check("rst_sig", 32'(sig_a), 32'(0));
    check("rst_vec_idx", 32'(vec_idx_a), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      sel  = tbl[i].inst;
      mode = tbl[i].cut_mode;
      push_exp(tbl[i].exp_sig, tbl[i].exp_pass, tbl[i].settle);
      run(tbl[i].settle, -1);
      repeat (2) @(negedge clk);
    end

    // abort during SETTLE of vector 2
    sel = 0; mode = 0;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_abort_vec", 32'(vec_idx_a), 32'(2));
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    check("abort_busy", 32'(busy_a), 32'(0));
    check("abort_done", 32'(done_a), 32'(0));
    check("abort_pass", 32'(pass_a), 32'(0));
    check("abort_sig", 32'(sig_a), 32'(8'h03));
    check("abort_vec", 32'(vec_idx_a), 32'(2));
    saw_done = 0;
    repeat (10) begin
      @(negedge clk);
      if (done_a) saw_done = 1;
    end
    check("abort_no_done", 32'(saw_done), 32'(0));
    check("abort_sig_frozen", 32'(sig_a), 32'(8'h03));
    push_exp(8'h0E, 1'b1, 1);
    run(1, -1);

    // start re-pulsed while busy is ignored
    push_exp(8'h0E, 1'b1, 1);
    run(1, 3);

    // asynchronous reset mid-run
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_cut_in", 32'(cut_in_a), 32'(0));
    check("arst_busy", 32'(busy_a), 32'(0));
    check("arst_done", 32'(done_a), 32'(0));
    check("arst_sig", 32'(sig_a), 32'(0));
    check("arst_vec_idx", 32'(vec_idx_a), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 0;
    repeat (10) begin
      @(negedge clk);
      if (done_a) saw_done = 1;
    end
    check("arst_no_done", 32'(saw_done), 32'(0));
    check("sb_empty", 32'(sb.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
